// File: rtl/dsp_sys_arr_pkg.sv
// dsp_sys_arr_pkg: shared types for the systolic-array operand feeder
package dsp_sys_arr_pkg;

    localparam int WORD_W = 32;

    typedef logic [WORD_W-1:0] word_t;

    typedef enum logic [1:0] {
        IDLE,
        FEED,
        DRAIN,
        DONE
    } feeder_state_t;

endpackage

// File: rtl/fifo_if.sv
// FIFO_if: first-word-fall-through FIFO handshake, one BW-lane word per pop
interface FIFO_if
    import dsp_sys_arr_pkg::*;
#(
    parameter int SIZE = 8,
    parameter int BW   = 4
) ();

    logic            pop;
    logic            push;
    logic            is_empty;
    word_t [BW-1:0]  dat_in;
    word_t [BW-1:0]  dat_out;

    modport master (output pop, push, dat_in, input is_empty, dat_out);
    modport slave  (input pop, push, dat_in, output is_empty, dat_out);

endinterface

// File: rtl/sys_arr_feeder_skew_line.sv
// skew_line: DEPTH-stage enabled delay line carrying a 32-bit word and its valid bit
module skew_line
    import dsp_sys_arr_pkg::*;
#(
    parameter int DEPTH = 1
) (
    input  logic  clk,
    input  logic  rst,
    input  logic  en,
    input  word_t din,
    input  logic  vin,
    output word_t dout,
    output logic  vout
);

    word_t            dat_q [DEPTH];
    logic [DEPTH-1:0] vld_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < DEPTH; k++) dat_q[k] <= '0;
            vld_q <= '0;
        end else if (en) begin
            dat_q[0] <= din;
            vld_q[0] <= vin;
            for (int k = 1; k < DEPTH; k++) begin
                dat_q[k] <= dat_q[k-1];
                vld_q[k] <= vld_q[k-1];
            end
        end
    end

    assign dout = dat_q[DEPTH-1];
    assign vout = vld_q[DEPTH-1];

endmodule

// File: rtl/sys_arr_feeder.sv
// sys_arr_feeder: pops FWFT words and feeds them diagonally skewed into a systolic array edge
// Optional stall counter output enabled by defining FEEDER_STALL_CNT_EN.
module sys_arr_feeder
    import dsp_sys_arr_pkg::*;
#(
    parameter int BW    = 4,
    parameter int K_MAX = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [$clog2(K_MAX):0] k_len,
    FIFO_if.master                 fif,
    input  logic                   arr_rdy,
    output word_t [BW-1:0]         arr_dat,
    output logic  [BW-1:0]         arr_vld,
    output logic                   busy,
    output logic                   done
`ifdef FEEDER_STALL_CNT_EN
    ,
    output logic [15:0]            stall_cnt
`endif
);

    localparam int KW = $clog2(K_MAX) + 1;
    localparam int DW = $clog2(BW + 1);
    localparam logic [DW-1:0] DRN_LAST = DW'(BW - 1);

    feeder_state_t   state, state_nx;
    logic [KW-1:0]   rem;
    logic [DW-1:0]   drn;
    logic            adv;
    logic            pop;

    assign adv = arr_rdy;
    assign pop = (state == FEED) && !fif.is_empty && adv && (rem != '0);

    assign fif.pop    = pop;
    assign fif.push   = 1'b0;
    assign fif.dat_in = '0;

    assign busy = (state == FEED) || (state == DRAIN);
    assign done = (state == DONE);

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = start ? ((k_len != '0) ? FEED : DONE) : IDLE;
            FEED:    state_nx = (pop && rem == KW'(1)) ? DRAIN : FEED;
            DRAIN:   state_nx = (adv && drn == DRN_LAST) ? DONE : DRAIN;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            rem   <= '0;
            drn   <= '0;
        end else begin
            state <= state_nx;
            if (state == IDLE && start)
                rem <= k_len;
            else if (pop)
                rem <= rem - KW'(1);
            drn <= (state == DRAIN) ? (adv ? drn + DW'(1) : drn) : '0;
        end
    end

    // Lane i sits i extra stages deep so each word lands on the array as a diagonal
    for (genvar i = 0; i < BW; i++) begin : g_lane
        skew_line #(.DEPTH(i + 1)) u_line (
            .clk  (clk),
            .rst  (rst),
            .en   (adv),
            .din  (pop ? fif.dat_out[i] : '0),
            .vin  (pop),
            .dout (arr_dat[i]),
            .vout (arr_vld[i])
        );
    end

`ifdef FEEDER_STALL_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            stall_cnt <= '0;
        else if (state == IDLE && start)
            stall_cnt <= '0;
        else if (state == FEED && adv && fif.is_empty && stall_cnt != 16'hFFFF)
            stall_cnt <= stall_cnt + 16'd1;
    end
`endif

    a_no_pop_empty: assert property (@(posedge clk) disable iff (rst) !(fif.pop && fif.is_empty));
    a_no_push:      assert property (@(posedge clk) disable iff (rst) !fif.push);
    a_done_pulse:   assert property (@(posedge clk) disable iff (rst) done |=> !done);

endmodule

// File: tb/tb_sys_arr_feeder.sv
// tb_sys_arr_feeder: directed bench with a queue-based FIFO and tile-level reference model
module tb_sys_arr_feeder;

    localparam int BW    = 4;
    localparam int K_MAX = 16;

    typedef logic [BW-1:0][31:0] vec_t;
    typedef struct { bit v; vec_t w; } ent_t;

    logic                   clk     = 1'b0;
    logic                   rst     = 1'b1;
    logic                   start   = 1'b0;
    logic                   arr_rdy = 1'b0;
    logic [$clog2(K_MAX):0] k_len   = '0;
    vec_t                   arr_dat;
    logic [BW-1:0]          arr_vld;
    logic                   busy, done;
`ifdef FEEDER_STALL_CNT_EN
    logic [15:0]            stall_cnt;
`endif

    FIFO_if #(.SIZE(8), .BW(BW)) fif_i ();

    sys_arr_feeder #(.BW(BW), .K_MAX(K_MAX)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .k_len   (k_len),
        .fif     (fif_i),
        .arr_rdy (arr_rdy),
        .arr_dat (arr_dat),
        .arr_vld (arr_vld),
        .busy    (busy),
        .done    (done)
`ifdef FEEDER_STALL_CNT_EN
        ,
        .stall_cnt (stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    vec_t fq[$];
    bit   pop_pend;
    int   checks, failures;

    // Model: words still owed, bubbles still owed, done pending, and every column entered so far
    int   m_rem, m_drain, m_stall;
    bit   m_done;
    ent_t hist[$];
    bit   e_pop, e_v;
    int   idx;
    ent_t ent;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s act=%0h exp=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic step(input bit rs, input bit s, input int k, input bit r, input bit g);
        @(negedge clk);
        if (pop_pend && fq.size() > 0) void'(fq.pop_front());
        rst     = rs;
        start   = s;
        k_len   = k[$clog2(K_MAX):0];
        arr_rdy = r;
        fif_i.is_empty = g || fq.size() == 0;
        fif_i.dat_out  = fq.size() > 0 ? fq[0] : '0;
    endtask

    task automatic load(input int t, input int k);
        vec_t w;
        for (int j = 0; j < k; j++) begin
            for (int i = 0; i < BW; i++) w[i] = 32'hA000_0000 | (t << 8) | (j << 4) | i;
            fq.push_back(w);
        end
    endtask

    task automatic tile(input int k, input int gl, input int gh, input int rl, input int rh,
                        input int xn, input int xk, input bit pin, output int lat);
        bit got = 1'b0;
        lat = -1;
        step(0, 1, k, 1, 0);
        for (int n = 1; n <= 40 && !got; n++) begin
            step(0, n == xn, xk, !(n >= rl && n <= rh), n >= gl && n <= gh);
            #2;
            if (pin && n == 4) chk("pin_vld_c4", arr_vld, 4'b0111);
            if (pin && n == 5) chk("pin_vld_c5", arr_vld, 4'b1110);
            if (pin && n == 5) chk("pin_dat3_c5", arr_dat[3], 32'hA000_0103);
            if (done) begin
                got = 1'b1;
                lat = n;
            end
        end
    endtask

    always @(negedge clk) begin
        #3;
        if (rst) begin
            m_rem = 0; m_drain = 0; m_done = 0; m_stall = 0;
            hist.delete();
        end
        e_pop = m_rem > 0 && !fif_i.is_empty && arr_rdy;
        chk("pop", fif_i.pop, e_pop);
        chk("push", fif_i.push, 1'b0);
        chk("busy", busy, m_rem > 0 || m_drain > 0);
        chk("done", done, m_done);
        for (int i = 0; i < BW; i++) begin
            idx = hist.size() - 1 - i;
            e_v = idx >= 0 && hist[idx].v;
            chk($sformatf("vld%0d", i), arr_vld[i], e_v);
            chk($sformatf("dat%0d", i), arr_dat[i], e_v ? hist[idx].w[i] : 32'd0);
        end
`ifdef FEEDER_STALL_CNT_EN
        chk("stall_cnt", stall_cnt, m_stall);
`endif
        pop_pend = fif_i.pop;
        if (!rst) begin
            if (arr_rdy) begin
                ent.v = e_pop;
                ent.w = e_pop ? fq[0] : '0;
                hist.push_back(ent);
                if (hist.size() > 64) void'(hist.pop_front());
            end
            if (m_done)
                m_done = 0;
            else if (m_rem == 0 && m_drain == 0) begin
                if (start) begin
                    m_stall = 0;
                    if (k_len != 0) m_rem = k_len;
                    else m_done = 1;
                end
            end else if (m_rem > 0) begin
                if (arr_rdy && fif_i.is_empty && m_stall < 65535) m_stall++;
                if (e_pop) begin
                    m_rem--;
                    if (m_rem == 0) m_drain = BW;
                end
            end else if (arr_rdy) begin
                m_drain--;
                if (m_drain == 0) m_done = 1;
            end
        end
    end

    initial begin
        int lat;
        fif_i.is_empty = 1'b1;
        fif_i.dat_out  = '0;
        step(1, 0, 0, 1, 0);
        #2;
        chk("rst_busy", busy, 1'b0);
        chk("rst_vld", arr_vld, '0);
        chk("rst_pop", fif_i.pop, 1'b0);
        step(1, 0, 0, 1, 0);
        step(0, 0, 0, 1, 0);

        load(1, 3);
        tile(3, 0, -1, 0, -1, 0, 0, 1'b1, lat);
        chk("lat_basic", lat, 8);

        load(2, 4);
        tile(4, 2, 3, 0, -1, 0, 0, 1'b0, lat);
        chk("lat_stall", lat, 11);
`ifdef FEEDER_STALL_CNT_EN
        chk("stall_lit", stall_cnt, 16'd2);
`endif

        load(3, 3);
        tile(3, 0, -1, 2, 4, 0, 0, 1'b0, lat);
        chk("lat_rdy_low", lat, 11);

        tile(0, 0, -1, 0, -1, 0, 0, 1'b0, lat);
        chk("lat_k0", lat, 1);

        load(4, 2);
        tile(2, 0, -1, 0, -1, 2, 5, 1'b0, lat);
        chk("lat_start_busy", lat, 7);
        step(0, 0, 0, 1, 0);
        chk("fifo_left", fq.size(), 0);

        load(5, 3);
        step(0, 1, 3, 1, 0);
        for (int n = 1; n <= 5; n++) step(0, 0, 0, 1, 0);
        #2;
        chk("pre_rst_busy", busy, 1'b1);
        step(1, 0, 0, 1, 0);
        #2;
        chk("mid_rst_busy", busy, 1'b0);
        chk("mid_rst_vld", arr_vld, '0);
        chk("mid_rst_dat", arr_dat, '0);
        step(0, 0, 0, 1, 0);

        load(6, 2);
        tile(2, 0, -1, 0, -1, 0, 0, 1'b0, lat);
        chk("lat_after_rst", lat, 7);
        step(0, 0, 0, 1, 0);
        step(0, 0, 0, 1, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
